// File: rtl/unidade_controle_multiciclo_pkg.sv
// Shared opcode/funct constants, ULAControl codes, state encoding and the
// per-state control word used by the multicycle MIPS control unit.
package unidade_controle_multiciclo_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ULA_AND = 3'b000;
   localparam logic [2:0] ULA_OR  = 3'b001;
   localparam logic [2:0] ULA_ADD = 3'b010;
   localparam logic [2:0] ULA_SUB = 3'b110;
   localparam logic [2:0] ULA_SLT = 3'b111;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_EXEC   = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11,
      S_JUMP   = 4'd12
   } state_t;

   typedef struct packed {
      logic       iord;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       memto_reg;
      logic       reg_write;
      logic       ula_src_a;
      logic [1:0] ula_src_b;
      logic [2:0] ula_control;
      logic [1:0] pc_src;
      logic       pc_write;
      logic       branch;
   } ctrl_t;

   localparam ctrl_t CTRL_RESET = '{ula_control: ULA_ADD, default: '0};

   // Control word presented while sitting in state s; r_ctl only matters in EXEC.
   function automatic ctrl_t ctrl_for(state_t s, logic [2:0] r_ctl);
      ctrl_t c;
      c = CTRL_RESET;
      case (s)
         S_FETCH:  begin c.ir_write = 1'b1; c.ula_src_b = 2'b01; c.pc_write = 1'b1; end
         S_DECODE: c.ula_src_b = 2'b11;
         S_MEMADR: begin c.ula_src_a = 1'b1; c.ula_src_b = 2'b10; end
         S_MEMRD:  c.iord = 1'b1;
         S_MEMWB:  begin c.memto_reg = 1'b1; c.reg_write = 1'b1; end
         S_MEMWR:  begin c.iord = 1'b1; c.mem_write = 1'b1; end
         S_EXEC:   begin c.ula_src_a = 1'b1; c.ula_control = r_ctl; end
         S_ALUWB:  begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
         S_BRANCH: begin
            c.ula_src_a = 1'b1; c.ula_control = ULA_SUB; c.pc_src = 2'b01; c.branch = 1'b1;
         end
         S_ADDIEX: begin c.ula_src_a = 1'b1; c.ula_src_b = 2'b10; end
         S_ADDIWB: c.reg_write = 1'b1;
         S_JUMP:   begin c.pc_src = 2'b10; c.pc_write = 1'b1; end
         default:  c = CTRL_RESET;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/unidade_controle_multiciclo_if.sv
// Instruction-field inputs and datapath control outputs of the multicycle control unit.
interface unidade_controle_multiciclo_if #(parameter int RETIRE_W = 8);
   logic [5:0]          Opcode;
   logic [5:0]          Funct;
   logic                Z;
   logic                IorD;
   logic                MemWrite;
   logic                IRWrite;
   logic                RegDst;
   logic                MemtoReg;
   logic                RegWrite;
   logic                ULASrcA;
   logic [1:0]          ULASrcB;
   logic [2:0]          ULAControl;
   logic [1:0]          PCSrc;
   logic                PCEn;
   logic                IllegalOp;
   logic [RETIRE_W-1:0] Retired;

   modport slave (
      input  Opcode, Funct, Z,
      output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ULASrcA, ULASrcB,
             ULAControl, PCSrc, PCEn, IllegalOp, Retired
   );
   modport master (
      output Opcode, Funct, Z,
      input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ULASrcA, ULASrcB,
             ULAControl, PCSrc, PCEn, IllegalOp, Retired
   );
endinterface

// File: rtl/unidade_controle_multiciclo_ula_decoder.sv
// Combinational R-type Funct decode into ULAControl plus a legality flag.
module unidade_controle_multiciclo_ula_decoder
   import unidade_controle_multiciclo_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] ula_control,
   output logic       legal
);
   always_comb begin
      ula_control = ULA_ADD;
      legal       = 1'b1;
      case (funct)
         FN_ADD:  ula_control = ULA_ADD;
         FN_SUB:  ula_control = ULA_SUB;
         FN_AND:  ula_control = ULA_AND;
         FN_OR:   ula_control = ULA_OR;
         FN_SLT:  ula_control = ULA_SLT;
         default: legal = 1'b0;
      endcase
   end
endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle MIPS control FSM; control outputs are registered from the next state,
// except PCEn (follows Z in BRANCH) and IllegalOp (decoded live from the IR in DECODE).
module unidade_controle_multiciclo
   import unidade_controle_multiciclo_pkg::*;
#(
   parameter int RETIRE_W = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   unidade_controle_multiciclo_if.slave  bus
);
   localparam logic [RETIRE_W-1:0] RET_ONE = {{(RETIRE_W-1){1'b0}}, 1'b1};

   state_t              state_q, state_d;
   ctrl_t               ctrl_q, ctrl_d;
   logic [RETIRE_W-1:0] retired_q, retired_d;
   logic [2:0]          dec_ctl;
   logic                dec_legal;
   logic                op_legal;

   unidade_controle_multiciclo_ula_decoder u_ula_decoder (
      .funct       (bus.Funct),
      .ula_control (dec_ctl),
      .legal       (dec_legal)
   );

   always_comb begin
      case (bus.Opcode)
         OP_RTYPE:                           op_legal = dec_legal;
         OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
         default:                            op_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      retired_d = retired_q;
      case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (bus.Opcode)
               OP_RTYPE:     state_d = dec_legal ? S_EXEC : S_FETCH;
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: state_d = (bus.Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = S_MEMWB;
         S_EXEC:   state_d = S_ALUWB;
         S_ADDIEX: state_d = S_ADDIWB;
         S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
            state_d   = S_FETCH;
            retired_d = retired_q + RET_ONE;
         end
         default:  state_d = S_IDLE;
      endcase
      // Funct is stable from DECODE on, so EXEC's ALU code can be registered on entry.
      ctrl_d = ctrl_for(state_d, dec_ctl);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         ctrl_q    <= CTRL_RESET;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         ctrl_q    <= ctrl_d;
         retired_q <= retired_d;
      end
   end

   assign bus.IorD       = ctrl_q.iord;
   assign bus.MemWrite   = ctrl_q.mem_write;
   assign bus.IRWrite    = ctrl_q.ir_write;
   assign bus.RegDst     = ctrl_q.reg_dst;
   assign bus.MemtoReg   = ctrl_q.memto_reg;
   assign bus.RegWrite   = ctrl_q.reg_write;
   assign bus.ULASrcA    = ctrl_q.ula_src_a;
   assign bus.ULASrcB    = ctrl_q.ula_src_b;
   assign bus.ULAControl = ctrl_q.ula_control;
   assign bus.PCSrc      = ctrl_q.pc_src;
   assign bus.PCEn       = ctrl_q.pc_write | (ctrl_q.branch & bus.Z);
   assign bus.IllegalOp  = (state_q == S_DECODE) && !op_legal;
   assign bus.Retired    = retired_q;
endmodule
